// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg: shared FSM encoding for serial_frame_link.
package serial_frame_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/pattern_counter.sv
// pattern_counter: wrapping up/down counter supplying the internal test pattern.
module pattern_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (en) count <= up ? count + 1'b1 : count - 1'b1;
    end
endmodule

// File: rtl/serial_frame_link.sv
// serial_frame_link: serialises a pattern or external word, reassembles the
// looped-back bits and flags any frame that came back different.
module serial_frame_link
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1,
    parameter int FCNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              src_sel,
    input  logic              count_dir,
    input  logic [WIDTH-1:0]  ext_data,
    input  logic              ext_valid,
    output logic              ext_ready,
    output logic              ser_out,
    output logic              ser_frame,
    input  logic              ser_in,
    output logic [WIDTH-1:0]  rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              mismatch,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam int IW = $clog2(WIDTH);
    state_t state, state_next;
    logic [WIDTH-1:0] tx, golden, rx, rx_next, pattern, word;
    logic [IW-1:0] bit_idx;
    logic src_ext, dir_q, load, step, last;
    assign word = src_sel ? ext_data : pattern;
    assign load = state == IDLE && (!src_sel || ext_valid);
    assign step = state == SHIFT && shift_en;
    assign last = bit_idx == IW'(WIDTH - 1);
    assign rx_next = MSB_FIRST ? {rx[WIDTH-2:0], ser_in} : {ser_in, rx[WIDTH-1:1]};
    pattern_counter #(.WIDTH(WIDTH)) u_pattern (
        .clk   (clk),
        .reset (reset),
        .en    (state == DONE && !src_ext),
        .up    (dir_q),
        .count (pattern)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        ext_ready  = state == IDLE && src_sel;
        busy       = state != IDLE;
        ser_frame  = state == SHIFT;
        state_next = state == IDLE  ? (load ? SHIFT : IDLE) :
                     state == SHIFT ? (step && last ? DONE : SHIFT) : IDLE;
    end
    // ser_out is preloaded with the first bit so it is valid in the first SHIFT cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            tx        <= '0;
            golden    <= '0;
            rx        <= '0;
            bit_idx   <= '0;
            src_ext   <= 1'b0;
            dir_q     <= 1'b0;
            ser_out   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            mismatch  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (load) begin
                tx      <= word;
                golden  <= word;
                src_ext <= src_sel;
                dir_q   <= count_dir;
                bit_idx <= '0;
                ser_out <= MSB_FIRST ? word[WIDTH-1] : word[0];
            end
            if (step) begin
                tx      <= MSB_FIRST ? tx << 1 : tx >> 1;
                rx      <= rx_next;
                bit_idx <= bit_idx + 1'b1;
                ser_out <= last ? 1'b0 : (MSB_FIRST ? tx[WIDTH-2] : tx[1]);
                if (last) begin
                    rx_data   <= rx_next;
                    rx_valid  <= 1'b1;
                    mismatch  <= mismatch | (rx_next != golden);
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/serial_frame_link.md
Name: serial_frame_link

Overview:
- Parametrised parallel-to-serial-to-parallel link tester. It is the next generation of the fixed 4-bit ripple-counter, serialize and register chain.
- Source word comes from an internal up/down pattern counter or from an external handshake port.
- Word is serialised one bit per shift strobe, received on a serial input (normally looped back), reassembled, presented with a valid pulse and checked against the sent word.
- Sits between the pattern/clock-divider logic and the LED/display outputs.

Parameters:
- WIDTH, 4, bits per frame (>=2).
- MSB_FIRST, 1, 1 = MSB transmitted first, 0 = LSB first.
- FCNT_W, 8, width of frame counter.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- reset  in  1  reset: synchronous, active-high.
- shift_en  in  1  bit-time strobe; one serial bit per cycle in which it is high.
- src_sel  in  1  0 = internal counter, 1 = ext_data.
- count_dir  in  1  1 = counter counts up, 0 = counts down.
- ext_data  in  WIDTH  external word.
- ext_valid  in  1  external word available.
- ext_ready  out  1  external word accepted when ext_valid&&ext_ready.
- ser_out  out  1  registered serial data.
- ser_frame  out  1  high while a frame's bits are on ser_out.
- ser_in  in  1  serial receive input.
- rx_data  out  WIDTH  last reassembled word, held until the next frame.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- busy  out  1  frame in progress.
- mismatch  out  1  sticky: a received word differed from the sent word.
- frame_cnt  out  FCNT_W  completed frames, wraps.

Behaviour:
- Reset values: all outputs 0, state IDLE, pattern counter 0.
- Reset mid-frame discards the partial frame: no rx_valid, and the counter restarts at 0.
- FSM IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - ext_ready = src_sel, combinational, IDLE only.
  - If src_sel=0, or src_sel=1 with ext_valid, on the edge: latch word into tx shift register and golden register; bit_idx=0; go to SHIFT.
  - Otherwise stay IDLE with ser_out=0.
  - src_sel and count_dir are sampled only in IDLE.
- SHIFT:
  - ser_frame=1, busy=1 (busy is also high in DONE).
  - ser_out shows the current bit from the first SHIFT cycle onward: MSB first if MSB_FIRST, else LSB first.
  - On each edge with shift_en=1: sample ser_in into the rx shift register in matching bit order, advance the tx register, bit_idx++.
  - With shift_en=0, all shift state holds.
  - After the WIDTH-th sampled bit, go to DONE.
- DONE, exactly one cycle:
  - rx_data = assembled word, rx_valid=1.
  - mismatch |= (assembled != golden).
  - frame_cnt++ (wraps to 0).
  - If the source was internal, counter ±1 mod 2^WIDTH.
  - Then go to IDLE.
- Timing with shift_en held high and internal source: IDLE 1 cycle, SHIFT WIDTH cycles, DONE 1 cycle, so frame period = WIDTH+2 cycles.
- First rx_valid is in cycle WIDTH+1 after reset release (cycle 0 = first cycle out of reset).
- Counter wrap: up goes 2^WIDTH-1 -> 0; down goes 0 -> 2^WIDTH-1.
- mismatch is cleared only by reset.
- shift_en is ignored in IDLE and DONE.

Decomposition:
- Package serial_frame_pkg holds the state enum (IDLE, SHIFT, DONE) and encoding constants.
- Sub-module pattern_counter (WIDTH, up/down, enable, sync reset, wrap) is natural.
- Tx/rx shift registers and FSM stay in the top module.

Test Plan:
- Counting up: WIDTH=4, src_sel=0, count_dir=1, shift_en=1, ser_in=ser_out. Expect rx_valid every 6 cycles, rx_data 0,1,2,3; frame_cnt 1,2,3,4; mismatch stays 0.
- Counting down with wrap: count_dir=0. Expect rx_data 0, F, E, D.
- Bit order:
  - External word 0xA, MSB_FIRST=1: ser_out 1,0,1,0 in SHIFT cycles.
  - MSB_FIRST=0 build, same word: ser_out 0,1,0,1.
  - rx_data=0xA in both cases.
- External handshake:
  - src_sel=1, ext_valid=0 for 10 cycles: stays IDLE, busy=0, ser_out=0.
  - Then ext_valid=1 with 0x6: ext_ready seen once per frame, rx_data=0x6.
- Error and reset:
  - ser_in = ~ser_out: first rx_valid gives rx_data=F for word 0; mismatch=1 and stays set.
  - Reset in SHIFT after 2 bits: next cycle busy=0, ser_out=0, mismatch=0, no rx_valid; next frame carries 0.
- Stalled strobe: shift_en high every 3rd cycle. Expect the same rx_data sequence as the counting-up case, with the frame stretched to 1+3·WIDTH+1 cycles.
